// File: rtl/memarb_pkg.sv
// rtl/memarb_pkg.sv - shared types and widths for the memory arbiter
package memarb_pkg;

    // Latency down-counter width; covers MEM_LATENCY up to 4
    localparam int LAT_W    = $clog2(4);
    // Starvation counter width; covers STARVE_LIMIT up to 15
    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

endpackage

// File: rtl/memarb_pick.sv
// rtl/memarb_pick.sv - combinational grant selector between fetch and data
module memarb_pick
    import memarb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  logic   starve_sat,
    output owner_t owner
);

    // Data has priority unless fetch has been waiting through the full starvation budget
    always_comb begin
        owner = OWN_IF;
        if (d_req && !(if_req && starve_sat)) begin
            owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port SRAM arbiter between fetch and data stages
module mem_arbiter
    import memarb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_ip,
    input  logic [ADDR_WIDTH-1:0]   if_addr_ip,
    output logic [DATA_WIDTH-1:0]   if_rdata_op,
    output logic                    if_done_op,
    input  logic                    d_req_ip,
    input  logic                    d_wren_ip,
    input  logic [ADDR_WIDTH-1:0]   d_addr_ip,
    input  logic [DATA_WIDTH-1:0]   d_wdata_ip,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb_ip,
    output logic [DATA_WIDTH-1:0]   d_rdata_op,
    output logic                    d_done_op,
    output logic                    mem_en_op,
    output logic                    mem_wren_op,
    output logic [ADDR_WIDTH-1:0]   mem_addr_op,
    output logic [DATA_WIDTH-1:0]   mem_wdata_op,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb_op,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_ip,
    output logic                    stall_if_op,
    output logic                    stall_d_op
);

    localparam int STRB_W = DATA_WIDTH / 8;

    state_t                state_q;
    state_t                state_d;
    owner_t                grant;
    owner_t                owner_q;
    logic                  wren_q;
    logic [LAT_W-1:0]      cnt_q;
    logic [STARVE_W-1:0]   starve_q;
    logic [DATA_WIDTH-1:0] resp_q;
    logic                  starve_sat;
    logic                  issue;

    assign starve_sat = (starve_q == STARVE_W'(STARVE_LIMIT));

    memarb_pick u_pick (
        .if_req     (if_req_ip),
        .d_req      (d_req_ip),
        .starve_sat (starve_sat),
        .owner      (grant)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the SRAM request, which is live only in the issue cycle
    always_comb begin
        state_d      = state_q;
        issue        = 1'b0;
        mem_en_op    = 1'b0;
        mem_wren_op  = 1'b0;
        mem_addr_op  = '0;
        mem_wdata_op = '0;
        mem_wstrb_op = '0;
        case (state_q)
            IDLE: begin
                if (if_req_ip || d_req_ip) begin
                    issue     = 1'b1;
                    mem_en_op = 1'b1;
                    state_d   = WAIT;
                    if (grant == OWN_D) begin
                        mem_wren_op  = d_wren_ip;
                        mem_addr_op  = d_addr_ip;
                        mem_wdata_op = d_wdata_ip;
                        mem_wstrb_op = d_wren_ip ? d_wstrb_ip : STRB_W'(0);
                    end else begin
                        mem_addr_op  = if_addr_ip;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Issue register, latency counter and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_IF;
            wren_q  <= 1'b0;
            cnt_q   <= '0;
            resp_q  <= '0;
        end else begin
            if (issue) begin
                owner_q <= grant;
                wren_q  <= (grant == OWN_D) && d_wren_ip;
                cnt_q   <= LAT_W'(MEM_LATENCY - 1);
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q   <= cnt_q - 1'b1;
            end
            // Writes leave the previous read data in place; it is don't-care for them
            if (state_q == WAIT && cnt_q == '0 && !wren_q) begin
                resp_q  <= mem_rdata_ip;
            end
        end
    end

    // Count data grants that bypassed a waiting fetch; any fetch grant or uncontended data grant clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else if (issue) begin
            if (grant == OWN_D && if_req_ip) begin
                if (!starve_sat) begin
                    starve_q <= starve_q + 1'b1;
                end
            end else begin
                starve_q <= '0;
            end
        end
    end

    assign if_done_op  = (state_q == RESP) && (owner_q == OWN_IF);
    assign d_done_op   = (state_q == RESP) && (owner_q == OWN_D);
    assign if_rdata_op = resp_q;
    assign d_rdata_op  = resp_q;
    assign stall_if_op = if_req_ip & ~if_done_op;
    assign stall_d_op  = d_req_ip & ~d_done_op;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: MEM_LATENCY=1, STARVE_LIMIT=4
    logic        a_if_req, a_if_done, a_d_req, a_d_wren, a_d_done;
    logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic [3:0]  a_d_wstrb, a_mem_wstrb;
    logic        a_mem_en, a_mem_wren, a_stall_if, a_stall_d;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    // Instance B: MEM_LATENCY=3, fetch only
    logic        b_if_req, b_if_done, b_d_done, b_mem_en, b_mem_wren, b_stall_if, b_stall_d;
    logic [31:0] b_if_addr, b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_wstrb;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .if_req_ip(a_if_req), .if_addr_ip(a_if_addr), .if_rdata_op(a_if_rdata), .if_done_op(a_if_done),
        .d_req_ip(a_d_req), .d_wren_ip(a_d_wren), .d_addr_ip(a_d_addr), .d_wdata_ip(a_d_wdata),
        .d_wstrb_ip(a_d_wstrb), .d_rdata_op(a_d_rdata), .d_done_op(a_d_done),
        .mem_en_op(a_mem_en), .mem_wren_op(a_mem_wren), .mem_addr_op(a_mem_addr),
        .mem_wdata_op(a_mem_wdata), .mem_wstrb_op(a_mem_wstrb), .mem_rdata_ip(a_mem_rdata),
        .stall_if_op(a_stall_if), .stall_d_op(a_stall_d)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .if_req_ip(b_if_req), .if_addr_ip(b_if_addr), .if_rdata_op(b_if_rdata), .if_done_op(b_if_done),
        .d_req_ip(1'b0), .d_wren_ip(1'b0), .d_addr_ip(32'h0), .d_wdata_ip(32'h0),
        .d_wstrb_ip(4'h0), .d_rdata_op(b_d_rdata), .d_done_op(b_d_done),
        .mem_en_op(b_mem_en), .mem_wren_op(b_mem_wren), .mem_addr_op(b_mem_addr),
        .mem_wdata_op(b_mem_wdata), .mem_wstrb_op(b_mem_wstrb), .mem_rdata_ip(b_mem_rdata),
        .stall_if_op(b_stall_if), .stall_d_op(b_stall_d)
    );

    // Shared SRAM contents; word index = addr[9:2]
    logic [31:0] mem [0:255];
    logic        a_rv;
    logic [31:0] a_rd;
    logic [3:1]  b_v;
    logic [31:0] b_d [1:3];

    // SRAM model for A: one-cycle read, byte-strobed write
    always @(posedge clk) begin
        if (rst) begin
            mem[16] <= 32'hAABBCCDD;
            mem[64] <= 32'hDEADBEEF;
            a_rv    <= 1'b0;
        end else begin
            a_rv <= a_mem_en && !a_mem_wren;
            if (a_mem_en) begin
                if (a_mem_wren) begin
                    for (int b = 0; b < 4; b++) begin
                        if (a_mem_wstrb[b]) mem[a_mem_addr[9:2]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
                    end
                end else begin
                    a_rd <= mem[a_mem_addr[9:2]];
                end
            end
        end
    end
    assign a_mem_rdata = a_rv ? a_rd : 32'hBAD0BAD0;

    // SRAM model for B: three-cycle read pipeline
    always @(posedge clk) begin
        if (rst) begin
            b_v <= '0;
        end else begin
            b_v    <= {b_v[2:1], b_mem_en && !b_mem_wren};
            b_d[1] <= mem[b_mem_addr[9:2]];
            b_d[2] <= b_d[1];
            b_d[3] <= b_d[2];
        end
    end
    assign b_mem_rdata = b_v[3] ? b_d[3] : 32'hBAD0BAD0;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: bit 32 set means compare read data
    logic [32:0] q_if [$];
    logic [32:0] q_d  [$];
    logic [32:0] e;
    int          done_order [$];
    int          done_cyc   [$];
    int          a_en_cnt = 0, a_if_done_cnt = 0, a_d_done_cnt = 0;
    int          starve_exp [6] = '{1, 1, 1, 1, 0, 1};

    always @(posedge clk) cyc++;

    // Completion monitor for A
    always @(negedge clk) begin
        if (!rst) begin
            if (a_mem_en) a_en_cnt++;
            if (a_if_done) begin
                a_if_done_cnt++;
                done_order.push_back(0);
                done_cyc.push_back(cyc);
                if (q_if.size() == 0) check("a_if_done_unexpected", 1, 0);
                else begin
                    e = q_if.pop_front();
                    if (e[32]) check("a_if_rdata", a_if_rdata, e[31:0]);
                end
            end
            if (a_d_done) begin
                a_d_done_cnt++;
                done_order.push_back(1);
                done_cyc.push_back(cyc);
                if (q_d.size() == 0) check("a_d_done_unexpected", 1, 0);
                else begin
                    e = q_d.pop_front();
                    if (e[32]) check("a_d_rdata", a_d_rdata, e[31:0]);
                end
            end
        end
    end

    // Wait for an A done pulse; latency counts negedges after the issue negedge
    task automatic a_wait_done(input string tag, input int exp_lat);
        int lat;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (a_if_done || a_d_done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        int base, en0, d0, lat, extra;
        rst = 1'b1;
        a_if_req = 0; a_if_addr = 0; a_d_req = 0; a_d_wren = 0;
        a_d_addr = 0; a_d_wdata = 0; a_d_wstrb = 0;
        b_if_req = 0; b_if_addr = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {a_if_done, a_d_done, a_mem_en, a_mem_wren, a_mem_wstrb, a_stall_if, a_stall_d}, 0);
        check("rst_rdata", {a_if_rdata, a_d_rdata}, 0);
        check("rst_mem", {a_mem_addr, a_mem_wdata}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fetch only, 0x100
        a_if_req = 1; a_if_addr = 32'h100;
        q_if.push_back({1'b1, 32'hDEADBEEF});
        @(negedge clk);
        check("f_issue", {a_mem_en, a_mem_wren, a_stall_if}, 3'b101);
        check("f_addr", a_mem_addr, 32'h100);
        @(negedge clk);
        check("f_wait", {a_mem_en, a_if_done, a_stall_if}, 3'b001);
        @(negedge clk);
        check("f_done", {a_if_done, a_stall_if, a_d_done}, 3'b100);
        @(posedge clk); #1;
        a_if_req = 0;

        // Data write, 0x40, low half
        a_d_req = 1; a_d_wren = 1; a_d_addr = 32'h40; a_d_wdata = 32'h12345678; a_d_wstrb = 4'b0011;
        q_d.push_back({1'b0, 32'h0});
        @(negedge clk);
        check("wr_issue", {a_mem_en, a_mem_wren, a_mem_wstrb, a_stall_d}, 7'b1100111);
        check("wr_data", {a_mem_addr, a_mem_wdata}, {32'h40, 32'h12345678});
        a_wait_done("wr", 2);
        check("wr_stall_at_done", a_stall_d, 0);
        @(posedge clk); #1;
        a_d_req = 0; a_d_wren = 0; a_d_wstrb = 0;

        // Read-back of 0x40
        a_d_req = 1;
        q_d.push_back({1'b1, 32'hAABB5678});
        @(negedge clk);
        check("rd_issue", {a_mem_en, a_mem_wren, a_mem_wstrb}, 6'b100000);
        a_wait_done("rd", 2);
        @(posedge clk); #1;
        a_d_req = 0;

        // Both held: four data grants, then fetch, then data again
        a_if_req = 1; a_if_addr = 32'h100; a_d_req = 1; a_d_addr = 32'h40;
        for (int i = 0; i < 5; i++) q_d.push_back({1'b1, 32'hAABB5678});
        q_if.push_back({1'b1, 32'hDEADBEEF});
        base = done_order.size();
        for (int k = 0; k < 60 && done_order.size() < base + 6; k++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        a_if_req = 0; a_d_req = 0;
        check("starve_cnt_done", done_order.size() - base, 6);
        if (done_order.size() >= base + 6) begin
            for (int i = 0; i < 6; i++) check($sformatf("starve_grant%0d", i), done_order[base+i], starve_exp[i]);
            check("b2b_period", done_cyc[base+5] - done_cyc[base+4], 3);
        end

        // Reset during WAIT of a data read
        a_d_req = 1; a_d_addr = 32'h40;
        d0 = a_d_done_cnt;
        @(negedge clk);
        check("mr_issue", a_mem_en, 1);
        @(posedge clk); #1;
        rst = 1; a_d_req = 0;
        @(negedge clk);
        check("mr_ctrl", {a_if_done, a_d_done, a_mem_en, a_mem_wren, a_mem_wstrb, a_stall_if, a_stall_d}, 0);
        check("mr_rdata", {a_if_rdata, a_d_rdata}, 0);
        @(posedge clk); #1;
        rst = 0; a_if_req = 1; a_if_addr = 32'h100;
        q_if.push_back({1'b1, 32'hDEADBEEF});
        @(negedge clk);
        check("mr_first_issue", {a_mem_en, a_mem_addr}, {1'b1, 32'h100});
        a_wait_done("mr_fetch", 2);
        @(posedge clk); #1;
        a_if_req = 0;
        check("mr_no_d_done", a_d_done_cnt - d0, 0);

        // Fetch req dropped the cycle after issue
        en0 = a_en_cnt; d0 = a_if_done_cnt;
        a_if_req = 1;
        q_if.push_back({1'b1, 32'hDEADBEEF});
        @(negedge clk);
        @(posedge clk); #1;
        a_if_req = 0;
        repeat (6) @(negedge clk);
        check("drop_en_cnt", a_en_cnt - en0, 1);
        check("drop_done_cnt", a_if_done_cnt - d0, 1);

        // MEM_LATENCY=3 fetch on B
        @(posedge clk); #1;
        b_if_req = 1; b_if_addr = 32'h100;
        @(negedge clk);
        check("b_issue", {b_mem_en, b_stall_if}, 2'b11);
        lat = -1; extra = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (b_mem_en) extra++;
            if (b_if_done) begin
                lat = k;
                check("b_rdata", b_if_rdata, 32'hDEADBEEF);
                check("b_d_done", b_d_done, 0);
                break;
            end
        end
        @(posedge clk); #1;
        b_if_req = 0;
        check("b_lat", lat, 4);
        check("b_single_en", extra, 0);

        check("sb_if_empty", q_if.size(), 0);
        check("sb_d_empty", q_d.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
